// File: rtl/mem_wb_stage_if.sv
// Bundle between the memory stage, the MEM/WB register and the register-file write port.
// The stage uses the slave view; the memory stage and register file use the master view.
interface mem_wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [4:0]       in_rd;
  logic             in_reg_write;
  logic [1:0]       in_result_src;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_pc_plus4;
  logic [XLEN-1:0]  in_load_data;
  logic [2:0]       in_funct3;
  logic [4:0]       rd;
  logic [XLEN-1:0]  wd;
  logic             RegWrite;
  logic             wb_valid;
  logic             load_err;
  logic [CNT_W-1:0] instret;

  modport master (
    output stall, flush, in_valid, in_rd, in_reg_write, in_result_src,
           in_alu_result, in_pc_plus4, in_load_data, in_funct3,
    input  rd, wd, RegWrite, wb_valid, load_err, instret
  );

  modport slave (
    input  stall, flush, in_valid, in_rd, in_reg_write, in_result_src,
           in_alu_result, in_pc_plus4, in_load_data, in_funct3,
    output rd, wd, RegWrite, wb_valid, load_err, instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment/extension, write-back select and
// registered register-file write port, plus the retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_RSVD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Picks the addressed byte/half out of the raw word and extends it to XLEN.
  function automatic logic [XLEN-1:0] align_load(
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] res_v;
    case (off)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res_v = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  res_v = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   res_v = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  res_v = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   res_v = word;
      default: res_v = {XLEN{1'b0}};
    endcase
    return res_v;
  endfunction

  logic             load_err_s;
  logic             misaligned_s;
  logic             illegal_s;
  logic             retire_s;
  logic             reg_write_s;
  logic [4:0]       rd_s;
  logic [XLEN-1:0]  wd_s;

  logic [4:0]       rd_r;
  logic [XLEN-1:0]  wd_r;
  logic             reg_write_r;
  logic             wb_valid_r;
  logic             load_err_r;
  logic [CNT_W-1:0] instret_r;

  // Load checks and the write-back value the next capturing edge will register.
  always_comb begin
    misaligned_s = 1'b0;
    illegal_s    = 1'b0;
    case (bus.in_funct3)
      F3_LB, F3_LBU: misaligned_s = 1'b0;
      F3_LH, F3_LHU: misaligned_s = bus.in_alu_result[0];
      F3_LW:         misaligned_s = (bus.in_alu_result[1:0] != 2'b00);
      default:       illegal_s    = 1'b1;
    endcase

    load_err_s = bus.in_valid & (bus.in_result_src == SRC_LOAD) & (misaligned_s | illegal_s);
    retire_s   = bus.in_valid & ~load_err_s;

    case (bus.in_result_src)
      SRC_ALU:  wd_s = bus.in_alu_result;
      SRC_LOAD: wd_s = align_load(bus.in_funct3, bus.in_alu_result[1:0], bus.in_load_data);
      SRC_PC4:  wd_s = bus.in_pc_plus4;
      default:  wd_s = {XLEN{1'b0}};
    endcase
    if (!retire_s) begin
      wd_s = {XLEN{1'b0}};
    end else begin
      wd_s = wd_s;
    end

    rd_s        = bus.in_valid ? bus.in_rd : 5'd0;
    reg_write_s = retire_s & bus.in_reg_write & (bus.in_rd != 5'd0)
                & (bus.in_result_src != SRC_RSVD);
  end

  // Pipeline register with flush > stall > capture priority; stall only clears the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r        <= 5'd0;
      wd_r        <= {XLEN{1'b0}};
      reg_write_r <= 1'b0;
      wb_valid_r  <= 1'b0;
      load_err_r  <= 1'b0;
      instret_r   <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      rd_r        <= 5'd0;
      wd_r        <= {XLEN{1'b0}};
      reg_write_r <= 1'b0;
      wb_valid_r  <= 1'b0;
      load_err_r  <= 1'b0;
    end else if (bus.stall) begin
      load_err_r  <= 1'b0;
    end else begin
      rd_r        <= rd_s;
      wd_r        <= wd_s;
      reg_write_r <= reg_write_s;
      wb_valid_r  <= bus.in_valid;
      load_err_r  <= load_err_s;
      if (retire_s) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign bus.rd       = rd_r;
  assign bus.wd       = wd_r;
  assign bus.RegWrite = reg_write_r;
  assign bus.wb_valid = wb_valid_r;
  assign bus.load_err = load_err_r;
  assign bus.instret  = instret_r;

endmodule
